// File: rtl/circle_motion_ctrl.sv
// circle_motion_ctrl: moves a circle centre once per frame and bounces it inside the active area
// clk25 / reset_n   : pixel clock, asynchronous active-low reset
// Vsync             : vertical sync, already in the clk25 domain
// key_pause_n       : raw active-low button, toggles run/pause
// key_speed_n       : raw active-low button, steps speed 1..MAX_SPEED
// CircleRow/Col     : registered circle centre
// moving / speed    : high while running / current per-frame step
module circle_motion_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RADIUS = 16,
  parameter int MAX_SPEED = 4,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       Vsync,
  input  logic       key_pause_n,
  input  logic       key_speed_n,
  output logic [8:0] CircleRow,
  output logic [9:0] CircleCol,
  output logic       moving,
  output logic [2:0] speed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [10:0] COL_MIN = 11'(RADIUS);
  localparam logic [10:0] COL_MAX = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] ROW_MIN = 11'(RADIUS);
  localparam logic [10:0] ROW_MAX = 11'(V_ACTIVE - 1 - RADIUS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t            state, state_nx;
  logic              vsync_q, tick;
  logic [1:0]        k1, k2, k3, press;
  logic [1:0][CW-1:0] cnt;
  logic              dir_x, dir_y, flip_x, flip_y;
  logic [10:0]       sp, col, row, col_up, row_up;
  logic [9:0]        col_nx;
  logic [8:0]        row_nx;

  // XOR with the polarity turns "active" into a 1 regardless of Vsync polarity
  assign tick = (Vsync ^ VSYNC_ACTIVE_LOW) & ~(vsync_q ^ VSYNC_ACTIVE_LOW);

  // bit 0 = pause key, bit 1 = speed key; falling edge of the synchronised level, gated by lockout
  assign press = ~k2 & k3 & {cnt[1] == '0, cnt[0] == '0};

  always_ff @(posedge clk25 or negedge reset_n)
    if (!reset_n) begin
      k1  <= '1;
      k2  <= '1;
      k3  <= '1;
      cnt <= '0;
    end else begin
      k1 <= {key_speed_n, key_pause_n};
      k2 <= k1;
      k3 <= k2;
      for (int i = 0; i < 2; i++)
        cnt[i] <= press[i] ? CW'(DEBOUNCE_CYCLES) : cnt[i] - CW'(cnt[i] != '0);
    end

  // 11-bit arithmetic so neither pos+speed nor the MIN+speed compare can wrap
  always_comb begin
    sp       = 11'(speed);
    col      = 11'(CircleCol);
    row      = 11'(CircleRow);
    col_up   = col + sp;
    row_up   = row + sp;
    flip_x   = dir_x ? col_up > COL_MAX : col < COL_MIN + sp;
    flip_y   = dir_y ? row_up > ROW_MAX : row < ROW_MIN + sp;
    col_nx   = 10'(flip_x ? (dir_x ? COL_MAX : COL_MIN) : (dir_x ? col_up : col - sp));
    row_nx   = 9'(flip_y ? (dir_y ? ROW_MAX : ROW_MIN) : (dir_y ? row_up : row - sp));
    state_nx = press[0] ? (state == PAUSED ? RUN : PAUSED) :
               (tick && state == IDLE) ? RUN : state;
  end

  always_ff @(posedge clk25 or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      moving    <= 1'b0;
      vsync_q   <= VSYNC_ACTIVE_LOW;
      CircleCol <= 10'(H_ACTIVE / 2);
      CircleRow <= 9'(V_ACTIVE / 2);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      speed     <= 3'd1;
    end else begin
      state   <= state_nx;
      moving  <= state_nx == RUN;
      vsync_q <= Vsync;
      if (tick && state == RUN) begin
        CircleCol <= col_nx;
        CircleRow <= row_nx;
        dir_x     <= dir_x ^ flip_x;
        dir_y     <= dir_y ^ flip_y;
      end
      if (press[1]) speed <= speed == 3'(MAX_SPEED) ? 3'd1 : speed + 3'd1;
    end
endmodule
